// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Timekeeping core of the stopwatch. The divided clock from the frequency
// divider is sampled as ordinary data: each rising edge becomes a one-cycle
// tick pulse. A prescaler turns TICKS_PER_SEC tick pulses into one step of a
// BCD MM:SS counter. The counter runs under an IDLE/RUN/PAUSE control machine
// with a clear button and a lap (display freeze) button.
//
// Parameters
//   TICKS_PER_SEC  divider rising edges per one-second step (1..255)
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   synchronous active-high reset, clears all state
//   TICK_IN     in   divided clock, asynchronous data
//   START_STOP  in   button level, rising edge toggles run/pause
//   CLEAR       in   button level, rising edge zeroes the count
//   LAP         in   button level, rising edge toggles display freeze
//   SEC_U       out  seconds units  (BCD 0-9)
//   SEC_T       out  seconds tens   (BCD 0-5)
//   MIN_U       out  minutes units  (BCD 0-9)
//   MIN_T       out  minutes tens   (BCD 0-5)
//   RUNNING     out  high in RUN
//   LAP_ACTIVE  out  high while the display is frozen
//   OVF         out  sticky, set when the count wraps 59:59 -> 00:00
//
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module stopwatch_counter #(
   parameter int unsigned TICKS_PER_SEC = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       TICK_IN,
   input  logic       START_STOP,
   input  logic       CLEAR,
   input  logic       LAP,
   output logic [3:0] SEC_U,
   output logic [3:0] SEC_T,
   output logic [3:0] MIN_U,
   output logic [3:0] MIN_T,
   output logic       RUNNING,
   output logic       LAP_ACTIVE,
   output logic       OVF
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   // Prescaler terminal value; the step happens on the tick that finds it here.
   localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_SEC - 1);

   // Bit positions inside the conditioned input vectors.
   localparam int unsigned B_TICK  = 0;
   localparam int unsigned B_SS    = 1;
   localparam int unsigned B_CLEAR = 2;
   localparam int unsigned B_LAP   = 3;

   // One BCD digit increment with wrap at 'top'. Returns {carry, digit}.
   // Any out-of-range digit also wraps to zero so a corrupted digit heals.
   function automatic logic [4:0] bcd_inc(input logic [3:0] digit,
                                          input logic [3:0] top);
      logic [4:0] res;
      if (digit >= top) begin
         res = {1'b1, 4'd0};
      end else begin
         res = {1'b0, digit + 4'd1};
      end
      return res;
   endfunction

   // ---------------------------------------------------------------- storage
   logic [3:0]  sync1_r;
   logic [3:0]  sync2_r;
   logic [3:0]  prev_r;
   logic [2:0]  armed_r;
   state_t      state_r;
   logic [7:0]  presc_r;
   logic [15:0] live_r;       // {MIN_T, MIN_U, SEC_T, SEC_U}
   logic [15:0] hold_r;
   logic        lap_r;
   logic        ovf_r;
   logic [15:0] disp_r;
   logic        running_r;

   // ------------------------------------------------------------ next state
   logic [3:0]  pulse_s;
   logic        tick_p_s;
   logic        ss_p_s;
   logic        clear_p_s;
   logic        lap_p_s;
   logic [4:0]  su_s;
   logic [4:0]  st_s;
   logic [4:0]  mu_s;
   logic [4:0]  mt_s;
   logic [15:0] inc_s;
   logic        wrap_s;
   logic        count_en_s;
   logic        step_s;
   state_t      state_nxt;
   logic [7:0]  presc_nxt;
   logic [15:0] live_nxt;
   logic [15:0] hold_nxt;
   logic        lap_nxt;
   logic        ovf_nxt;
   logic [15:0] disp_nxt;
   logic        running_nxt;

   // Rising-edge detection on the synchronized inputs. The synchronizer and
   // history flops restart at zero after reset, so edges are held off until
   // the chain has flushed (armed_r full); a level already high when reset
   // drops is then seen as history rather than as a new edge.
   always_comb begin
      pulse_s = 4'd0;
      if (armed_r[2]) begin
         pulse_s = sync2_r & ~prev_r;
      end else begin
         pulse_s = 4'd0;
      end
   end

   assign tick_p_s  = pulse_s[B_TICK];
   assign ss_p_s    = pulse_s[B_SS];
   assign clear_p_s = pulse_s[B_CLEAR];
   assign lap_p_s   = pulse_s[B_LAP];

   // Ripple the one-second increment through the four BCD digits.
   always_comb begin
      su_s = 5'd0;
      st_s = 5'd0;
      mu_s = 5'd0;
      mt_s = 5'd0;
      su_s = bcd_inc(live_r[3:0], 4'd9);
      if (su_s[4]) begin
         st_s = bcd_inc(live_r[7:4], 4'd5);
      end else begin
         st_s = {1'b0, live_r[7:4]};
      end
      if (st_s[4]) begin
         mu_s = bcd_inc(live_r[11:8], 4'd9);
      end else begin
         mu_s = {1'b0, live_r[11:8]};
      end
      if (mu_s[4]) begin
         mt_s = bcd_inc(live_r[15:12], 4'd5);
      end else begin
         mt_s = {1'b0, live_r[15:12]};
      end
   end

   assign inc_s  = {mt_s[3:0], mu_s[3:0], st_s[3:0], su_s[3:0]};
   assign wrap_s = mt_s[4];

   // A stop pulse in RUN takes effect in the same cycle, so a coincident tick
   // neither steps nor advances the prescaler.
   assign count_en_s = (state_r == ST_RUN) && tick_p_s && !ss_p_s;

   // Control machine, prescaler, live count, lap hold and overflow flag.
   always_comb begin
      state_nxt = state_r;
      presc_nxt = presc_r;
      live_nxt  = live_r;
      hold_nxt  = hold_r;
      lap_nxt   = lap_r;
      ovf_nxt   = ovf_r;
      step_s    = 1'b0;

      if (clear_p_s) begin
         // Clear wins over every other event in the cycle.
         state_nxt = ST_IDLE;
         presc_nxt = 8'd0;
         live_nxt  = 16'd0;
         lap_nxt   = 1'b0;
         ovf_nxt   = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ss_p_s) state_nxt = ST_RUN;
               else        state_nxt = ST_IDLE;
            end
            ST_RUN: begin
               if (ss_p_s) state_nxt = ST_PAUSE;
               else        state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
               if (ss_p_s) state_nxt = ST_RUN;
               else        state_nxt = ST_PAUSE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase

         // Prescaler only moves in RUN; in PAUSE it simply holds.
         if (count_en_s) begin
            if (presc_r >= LAST_TICK) begin
               presc_nxt = 8'd0;
               step_s    = 1'b1;
            end else begin
               presc_nxt = presc_r + 8'd1;
               step_s    = 1'b0;
            end
         end else begin
            presc_nxt = presc_r;
            step_s    = 1'b0;
         end

         if (step_s) begin
            live_nxt = inc_s;
            if (wrap_s) ovf_nxt = 1'b1;
            else        ovf_nxt = ovf_r;
         end else begin
            live_nxt = live_r;
            ovf_nxt  = ovf_r;
         end

         // The hold register captures live_r, i.e. the count before any
         // step landing in this same cycle.
         if (lap_p_s) begin
            if (lap_r) begin
               lap_nxt  = 1'b0;
               hold_nxt = hold_r;
            end else if (state_r != ST_IDLE) begin
               lap_nxt  = 1'b1;
               hold_nxt = live_r;
            end else begin
               lap_nxt  = lap_r;
               hold_nxt = hold_r;
            end
         end else begin
            lap_nxt  = lap_r;
            hold_nxt = hold_r;
         end
      end

      if (lap_nxt) begin
         disp_nxt = hold_nxt;
      end else begin
         disp_nxt = live_nxt;
      end
      running_nxt = (state_nxt == ST_RUN);
   end

   // All state and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_r   <= 4'd0;
         sync2_r   <= 4'd0;
         prev_r    <= 4'd0;
         armed_r   <= 3'd0;
         state_r   <= ST_IDLE;
         presc_r   <= 8'd0;
         live_r    <= 16'd0;
         hold_r    <= 16'd0;
         lap_r     <= 1'b0;
         ovf_r     <= 1'b0;
         disp_r    <= 16'd0;
         running_r <= 1'b0;
      end else begin
         sync1_r   <= {LAP, CLEAR, START_STOP, TICK_IN};
         sync2_r   <= sync1_r;
         prev_r    <= sync2_r;
         armed_r   <= {armed_r[1:0], 1'b1};
         state_r   <= state_nxt;
         presc_r   <= presc_nxt;
         live_r    <= live_nxt;
         hold_r    <= hold_nxt;
         lap_r     <= lap_nxt;
         ovf_r     <= ovf_nxt;
         disp_r    <= disp_nxt;
         running_r <= running_nxt;
      end
   end

   assign SEC_U      = disp_r[3:0];
   assign SEC_T      = disp_r[7:4];
   assign MIN_U      = disp_r[11:8];
   assign MIN_T      = disp_r[15:12];
   assign RUNNING    = running_r;
   assign LAP_ACTIVE = lap_r;
   assign OVF        = ovf_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Drives two stopwatch_counter instances (TICKS_PER_SEC = 1 and 4) from the
// same buttons and divided clock. A reference model keeps the number of
// divider edges seen while running since the last clear; the expected display
// is that total divided by TICKS_PER_SEC, modulo one hour, unless frozen.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

   logic clk = 1'b0;
   logic rst;
   logic tick_in;
   logic start_stop;
   logic clear;
   logic lap;

   logic [3:0] su1, st1, mu1, mt1;
   logic [3:0] su4, st4, mu4, mt4;
   logic       run1, lapa1, ovf1;
   logic       run4, lapa4, ovf4;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 idle, 1 run, 2 pause
   int m_state = 0;
   int m_ticks = 0;
   bit m_lap   = 1'b0;
   int m_hold1 = 0;
   int m_hold4 = 0;

   always #5 clk = ~clk;

   stopwatch_counter #(.TICKS_PER_SEC(1)) dut1 (
      .CLK(clk), .RST(rst), .TICK_IN(tick_in), .START_STOP(start_stop),
      .CLEAR(clear), .LAP(lap),
      .SEC_U(su1), .SEC_T(st1), .MIN_U(mu1), .MIN_T(mt1),
      .RUNNING(run1), .LAP_ACTIVE(lapa1), .OVF(ovf1)
   );

   stopwatch_counter #(.TICKS_PER_SEC(4)) dut4 (
      .CLK(clk), .RST(rst), .TICK_IN(tick_in), .START_STOP(start_stop),
      .CLEAR(clear), .LAP(lap),
      .SEC_U(su4), .SEC_T(st4), .MIN_U(mu4), .MIN_T(mt4),
      .RUNNING(run4), .LAP_ACTIVE(lapa4), .OVF(ovf4)
   );

   wire [15:0] disp1 = {mt1, mu1, st1, su1};
   wire [15:0] disp4 = {mt4, mu4, st4, su4};

   function automatic logic [15:0] to_bcd(input int secs);
      int mm, ss;
      mm = secs / 60;
      ss = secs % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [15:0] exp_disp(input int tps);
      int s;
      if (m_lap) s = (tps == 1) ? m_hold1 : m_hold4;
      else       s = (m_ticks / tps) % 3600;
      return to_bcd(s);
   endfunction

   function automatic logic exp_ovf(input int tps);
      return ((m_ticks / tps) >= 3600) ? 1'b1 : 1'b0;
   endfunction

   function automatic logic exp_run();
      return (m_state == 1) ? 1'b1 : 1'b0;
   endfunction

   // ---------------------------------------------------------- stimulus
   task automatic model_reset();
      m_state = 0; m_ticks = 0; m_lap = 1'b0; m_hold1 = 0; m_hold4 = 0;
   endtask

   task automatic tick_edge();
      int hi, lo;
      hi = $urandom_range(2, 4);
      lo = $urandom_range(2, 4);
      tick_in = 1'b1;
      repeat (hi) @(negedge clk);
      tick_in = 1'b0;
      repeat (lo) @(negedge clk);
      if (m_state == 1) m_ticks++;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick_edge();
   endtask

   task automatic press_ss();
      start_stop = 1'b1;
      repeat (3) @(negedge clk);
      start_stop = 1'b0;
      repeat (3) @(negedge clk);
      if (m_state == 1) m_state = 2;
      else              m_state = 1;
   endtask

   task automatic press_lap();
      lap = 1'b1;
      repeat (3) @(negedge clk);
      lap = 1'b0;
      repeat (3) @(negedge clk);
      if (m_lap) begin
         m_lap = 1'b0;
      end else if (m_state != 0) begin
         m_lap   = 1'b1;
         m_hold1 = m_ticks % 3600;
         m_hold4 = (m_ticks / 4) % 3600;
      end
   endtask

   task automatic press_clear();
      clear = 1'b1;
      repeat (3) @(negedge clk);
      clear = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
   endtask

   // ---------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b1;
      start_stop = 1'b1;   // held high across reset release: must not start
      @(negedge clk);
      checks++; if (disp1 !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h want 0000", disp1); end
      checks++; if (run1 !== 1'b0 || lapa1 !== 1'b0 || ovf1 !== 1'b0) begin
         errors++; $display("FAIL reset_flags got run=%b lap=%b ovf=%b want 0 0 0", run1, lapa1, ovf1); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (6) @(negedge clk);
      checks++; if (run1 !== 1'b0) begin errors++; $display("FAIL reset_held_button got run=%b want 0", run1); end
      start_stop = 1'b0;
      repeat (3) @(negedge clk);
      ticks(10);
      checks++; if (disp1 !== 16'h0000 || disp4 !== 16'h0000) begin
         errors++; $display("FAIL idle_ticks got %h/%h want 0000/0000", disp1, disp4); end
      checks++; if (run1 !== 1'b0 || ovf1 !== 1'b0) begin
         errors++; $display("FAIL idle_flags got run=%b ovf=%b want 0 0", run1, ovf1); end
   endtask

   task automatic test_basic();
      press_clear();
      press_ss();
      ticks(75);
      checks++; if (disp1 !== 16'h0115) begin errors++; $display("FAIL basic_disp1 got %h want 0115", disp1); end
      checks++; if (disp4 !== exp_disp(4)) begin errors++; $display("FAIL basic_disp4 got %h want %h", disp4, exp_disp(4)); end
      checks++; if (run1 !== 1'b1) begin errors++; $display("FAIL basic_running got %b want 1", run1); end
   endtask

   task automatic test_pause();
      press_clear();
      press_ss();
      ticks(5);
      press_ss();
      ticks(5);
      checks++; if (disp1 !== 16'h0005 || run1 !== 1'b0) begin
         errors++; $display("FAIL pause_hold got %h run=%b want 0005 run=0", disp1, run1); end
      press_ss();
      ticks(3);
      checks++; if (disp1 !== 16'h0008) begin errors++; $display("FAIL pause_resume got %h want 0008", disp1); end
      checks++; if (disp4 !== exp_disp(4)) begin errors++; $display("FAIL pause_disp4 got %h want %h", disp4, exp_disp(4)); end
      // divide-by-4: 2 edges, pause, 2 ignored edges, resume, 2 edges -> one step
      press_clear();
      press_ss();
      ticks(2);
      press_ss();
      ticks(2);
      press_ss();
      ticks(1);
      checks++; if (disp4 !== 16'h0000) begin errors++; $display("FAIL presc_early got %h want 0000", disp4); end
      ticks(1);
      checks++; if (disp4 !== 16'h0001) begin errors++; $display("FAIL presc_step got %h want 0001", disp4); end
   endtask

   task automatic test_wrap();
      press_clear();
      press_ss();
      ticks(3599);
      checks++; if (disp1 !== 16'h5959 || ovf1 !== 1'b0) begin
         errors++; $display("FAIL wrap_pre got %h ovf=%b want 5959 ovf=0", disp1, ovf1); end
      ticks(1);
      checks++; if (disp1 !== 16'h0000 || ovf1 !== 1'b1 || run1 !== 1'b1) begin
         errors++; $display("FAIL wrap_edge got %h ovf=%b run=%b want 0000 1 1", disp1, ovf1, run1); end
      ticks(1);
      checks++; if (disp1 !== 16'h0001 || ovf1 !== 1'b1) begin
         errors++; $display("FAIL wrap_post got %h ovf=%b want 0001 ovf=1", disp1, ovf1); end
      checks++; if (disp4 !== exp_disp(4) || ovf4 !== exp_ovf(4)) begin
         errors++; $display("FAIL wrap_disp4 got %h ovf=%b want %h ovf=%b", disp4, ovf4, exp_disp(4), exp_ovf(4)); end
   endtask

   task automatic test_lap();
      press_clear();
      press_lap();
      checks++; if (lapa1 !== 1'b0) begin errors++; $display("FAIL lap_idle got %b want 0", lapa1); end
      press_ss();
      ticks(10);
      press_lap();
      checks++; if (disp1 !== 16'h0010 || lapa1 !== 1'b1) begin
         errors++; $display("FAIL lap_freeze got %h lap=%b want 0010 lap=1", disp1, lapa1); end
      for (int k = 0; k < 5; k++) begin
         tick_edge();
         checks++; if (disp1 !== 16'h0010) begin errors++; $display("FAIL lap_hold%0d got %h want 0010", k, disp1); end
      end
      press_lap();
      checks++; if (disp1 !== 16'h0015 || lapa1 !== 1'b0) begin
         errors++; $display("FAIL lap_release got %h lap=%b want 0015 lap=0", disp1, lapa1); end
      checks++; if (disp4 !== exp_disp(4)) begin errors++; $display("FAIL lap_disp4 got %h want %h", disp4, exp_disp(4)); end
   endtask

   task automatic test_priority();
      press_clear();
      press_ss();
      ticks(7);
      clear   = 1'b1;
      tick_in = 1'b1;
      repeat (3) @(negedge clk);
      clear   = 1'b0;
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      checks++; if (disp1 !== 16'h0000 || run1 !== 1'b0 || disp4 !== 16'h0000) begin
         errors++; $display("FAIL clear_tick got %h/%h run=%b want 0000/0000 run=0", disp1, disp4, run1); end
      ticks(1);
      checks++; if (disp1 !== 16'h0000) begin errors++; $display("FAIL clear_idle got %h want 0000", disp1); end
   endtask

   task automatic test_rst_mid();
      press_ss();
      ticks(42);
      press_lap();
      checks++; if (disp1 !== 16'h0042 || lapa1 !== 1'b1) begin
         errors++; $display("FAIL rst_pre got %h lap=%b want 0042 lap=1", disp1, lapa1); end
      tick_in = 1'b1;
      rst     = 1'b1;
      @(negedge clk);
      checks++; if (disp1 !== 16'h0000 || run1 !== 1'b0 || lapa1 !== 1'b0) begin
         errors++; $display("FAIL rst_mid got %h run=%b lap=%b want 0000 0 0", disp1, run1, lapa1); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
      press_ss();
      checks++; if (disp1 !== 16'h0000 || run1 !== 1'b1) begin
         errors++; $display("FAIL rst_restart got %h run=%b want 0000 run=1", disp1, run1); end
   endtask

   task automatic test_random();
      int r;
      press_clear();
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 19);
         if (r < 13)      tick_edge();
         else if (r < 16) press_ss();
         else if (r < 19) press_lap();
         else             press_clear();
         checks++; if (disp1 !== exp_disp(1)) begin errors++; $display("FAIL rand_disp1 step %0d got %h want %h", i, disp1, exp_disp(1)); end
         checks++; if (disp4 !== exp_disp(4)) begin errors++; $display("FAIL rand_disp4 step %0d got %h want %h", i, disp4, exp_disp(4)); end
         checks++; if (run1 !== exp_run() || run4 !== exp_run()) begin
            errors++; $display("FAIL rand_running step %0d got %b/%b want %b", i, run1, run4, exp_run()); end
         checks++; if (lapa1 !== m_lap || lapa4 !== m_lap) begin
            errors++; $display("FAIL rand_lap step %0d got %b/%b want %b", i, lapa1, lapa4, m_lap); end
         checks++; if (ovf1 !== exp_ovf(1) || ovf4 !== exp_ovf(4)) begin
            errors++; $display("FAIL rand_ovf step %0d got %b/%b want %b/%b", i, ovf1, ovf4, exp_ovf(1), exp_ovf(4)); end
      end
   endtask

   initial begin
      rst = 1'b1; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_pause();
      test_wrap();
      test_lap();
      test_priority();
      test_rst_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
